apb_master_fsm: RTL and testbench
=================================

// Module: apb_master_fsm
// PURPOSE
//   APB3 initiator: turns a single-outstanding command stream (valid/ready) into APB3
//   SETUP/ACCESS transfers and returns a response (rdata, slverr, timeout) on a valid/ready channel.
//   Drives the master side of the APB bus into the apb2axi bridge's APB slave port.
//   Used as the bus-driving engine for the bench and for on-chip register initiators.
// PARAMETERS
//   ADDR_WIDTH      32   PADDR / cmd_addr width
//   DATA_WIDTH      32   PWDATA / PRDATA / data-path width
//   TIMEOUT_CYCLES  256  max ACCESS cycles with PREADY=0 before abort; 0 = timeout disabled
// PORTS
//   PCLK         in   1           clock, all logic on posedge
//   PRESETn      in   1           synchronous, active-low reset
//   cmd_valid    in   1           command present
//   cmd_ready    out  1           command accepted when cmd_valid & cmd_ready
//   cmd_addr     in   ADDR_WIDTH  transfer address
//   cmd_write    in   1           1 = write, 0 = read
//   cmd_wdata    in   DATA_WIDTH  write data
//   rsp_valid    out  1           response present
//   rsp_ready    in   1           response consumed when rsp_valid & rsp_ready
//   rsp_rdata    out  DATA_WIDTH  read data (0 for writes and timeouts)
//   rsp_slverr   out  1           PSLVERR sampled at completion, or 1 on timeout
//   rsp_timeout  out  1           transfer aborted by timeout
//   PADDR        out  ADDR_WIDTH  APB address
//   PWRITE       out  1           APB direction
//   PWDATA       out  DATA_WIDTH  APB write data
//   PSEL         out  1           APB select
//   PENABLE      out  1           APB enable
//   PRDATA       in   DATA_WIDTH  APB read data
//   PREADY       in   1           APB ready
//   PSLVERR      in   1           APB slave error
// BEHAVIOUR
//   - Reset (PRESETn=0 at posedge): state IDLE; all outputs 0 except cmd_ready, which is 1 in the
//     first cycle after reset is released. Reset mid-transfer: PSEL/PENABLE drop at that edge;
//     no response is produced; the wait counter clears.
//   - FSM IDLE->SETUP->ACCESS->RESP->IDLE; one transfer outstanding; cmd_ready = (state==IDLE).
//   - IDLE: on cmd_valid, latch addr/write/wdata into PADDR/PWRITE/PWDATA; go to SETUP.
//   - SETUP (1 cycle): PSEL=1, PENABLE=0; always goes to ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1. With PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR
//     into rsp_*; go to RESP. With PREADY=0: wait counter += 1; stay in ACCESS.
//   - Timeout: when counter reaches TIMEOUT_CYCLES in ACCESS with PREADY=0 (TIMEOUT_CYCLES!=0),
//     abort: rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; go to RESP. PREADY=1 in the same cycle as
//     the limit wins, so the transfer completes normally.
//   - RESP: rsp_valid=1, PSEL=PENABLE=0; rsp_* stable until rsp_ready=1; then go to IDLE and clear
//     the counter. No new command is accepted in RESP.
//   - Latency: command accepted at edge N -> SETUP in cycle N+1 -> ACCESS in cycle N+2 ->
//     rsp_valid in cycle N+3 with zero wait states. Minimum 4 cycles per transfer.
//   - PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS and hold their last
//     value in IDLE/RESP. PENABLE is never 1 without PSEL.
//   - PRDATA, PREADY and PSLVERR are ignored outside ACCESS.
//   - Counter width: $clog2(TIMEOUT_CYCLES+1); the counter saturates and does not wrap.
// TESTING
//   1. Write 0x10 <= 0xDEADBEEF, PREADY tied 1 -> SETUP then ACCESS one cycle each; rsp_valid 3
//      cycles after accept; slverr=0, timeout=0, rdata=0.
//   2. Read 0x24, 3 wait states, PRDATA=0xCAFE0001 -> ACCESS lasts 4 cycles; rsp_rdata=0xCAFE0001;
//      PADDR stable throughout.
//   3. Read with PSLVERR=1 at completion -> rsp_slverr=1, rsp_timeout=0.
//   4. TIMEOUT_CYCLES=8, PREADY held 0 -> abort after 8 ACCESS cycles; PSEL drops; slverr=1,
//      timeout=1; next command proceeds normally.
//   5. rsp_ready held 0 for 5 cycles with cmd_valid high -> cmd_ready=0 and no PSEL until the
//      response is consumed.
//   6. PRESETn asserted during ACCESS -> PSEL/PENABLE/rsp_valid are 0 the next cycle; cmd_ready=1
//      after release.

Source files
------------

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB3 initiator turning a valid/ready command stream into SETUP/ACCESS transfers
module apb_master_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    state_t state_q, state_d;
    logic [CW-1:0] wait_cnt;
    logic timeout_hit;
    // the limit is reached on the wait cycle that would bring the counter to TIMEOUT_CYCLES
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && (wait_cnt == LIMIT);
    assign cmd_ready   = PRESETn && (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    // state register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end
    // next-state logic; PREADY completing in the limit cycle takes priority over the abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (PREADY || timeout_hit) ? RESP : ACCESS;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // bus request latch, response capture and saturating wait counter
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
            end
            if (state_q == ACCESS && PREADY) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_slverr  <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (state_q == ACCESS && timeout_hit) begin
                rsp_rdata   <= '0;
                rsp_slverr  <= 1'b1;
                rsp_timeout <= 1'b1;
            end
            if (state_q == RESP && rsp_ready)
                wait_cnt <= '0;
            else if (state_q == ACCESS && !PREADY && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: randomized lockstep bench against a per-transaction outcome model
module tb_apb_master_fsm;
    localparam int TO = 8;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct packed {
        int          n_acc;
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } exp_t;

    apb_master_fsm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave completes after w wait states; the initiator gives up once TO ACCESS cycles pass unready.
    function automatic exp_t predict(input logic wr, input int w, input logic [31:0] rd, input logic pe);
        exp_t e;
        if (w >= TO) begin
            e.n_acc = TO; e.rdata = '0; e.slverr = 1'b1; e.timeout = 1'b1;
        end else begin
            e.n_acc = w + 1; e.rdata = wr ? 32'h0 : rd; e.slverr = pe; e.timeout = 1'b0;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic junk_bus();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
    endtask

    // one full transfer, called at a negedge with the DUT idle
    task automatic run_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input int w, input logic [31:0] rd, input logic pe, input int hold);
        exp_t e;
        e = predict(wr, w, rd, pe);
        cmd_addr = a; cmd_write = wr; cmd_wdata = wd; cmd_valid = 1'b1; rsp_ready = 1'b0;
        check("idle_cmd_ready", cmd_ready, 1);
        junk_bus();
        step();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
        check("setup_psel", PSEL, 1);
        check("setup_penable", PENABLE, 0);
        check("setup_paddr", PADDR, a);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, wd);
        check("setup_rsp_valid", rsp_valid, 0);
        check("setup_cmd_ready", cmd_ready, 0);
        junk_bus();
        for (int k = 0; k < e.n_acc; k++) begin
            step();
            check("acc_psel", PSEL, 1);
            check("acc_penable", PENABLE, 1);
            check("acc_paddr", PADDR, a);
            check("acc_pwdata", PWDATA, wd);
            check("acc_rsp_valid", rsp_valid, 0);
            PREADY  = (k == w);
            PRDATA  = (k == w) ? rd : $urandom;
            PSLVERR = (k == w) ? pe : 1'($urandom);
        end
        step();
        junk_bus();
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_psel", PSEL, 0);
            check("rsp_penable", PENABLE, 0);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_slverr", rsp_slverr, e.slverr);
            check("rsp_timeout", rsp_timeout, e.timeout);
            check("rsp_cmd_ready", cmd_ready, 0);
            if (h < hold) begin
                cmd_valid = 1'b1; cmd_addr = $urandom;
                junk_bus();
                step();
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_cmd_ready", cmd_ready, 1);
        check("done_psel", PSEL, 0);
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_flags", {rsp_slverr, rsp_timeout, PWRITE}, 0);
        PRESETn = 1'b1;
        step();
        check("post_rst_cmd_ready", cmd_ready, 1);

        run_txn(32'h10, 1'b1, 32'hDEADBEEF, 0, 32'h12345678, 1'b0, 0);
        run_txn(32'h24, 1'b0, 32'h0, 3, 32'hCAFE0001, 1'b0, 0);
        run_txn(32'h28, 1'b0, 32'h0, 1, 32'hA5A5A5A5, 1'b1, 0);
        run_txn(32'h2C, 1'b0, 32'h0, 20, 32'h11111111, 1'b0, 0);
        run_txn(32'h30, 1'b1, 32'h0BADF00D, 0, 32'h0, 1'b0, 0);
        run_txn(32'h34, 1'b0, 32'h0, TO - 1, 32'h77777777, 1'b0, 0);
        run_txn(32'h38, 1'b0, 32'h0, TO, 32'h88888888, 1'b0, 0);
        run_txn(32'h3C, 1'b1, 32'h55AA55AA, 2, 32'h0, 1'b0, 5);

        // reset during ACCESS after some wait cycles, then a transfer needing a fresh counter
        cmd_addr = 32'h40; cmd_write = 1'b0; cmd_valid = 1'b1; PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("pre_rst_penable", PENABLE, 1);
        PRESETn = 1'b0;
        step();
        check("midrst_psel", PSEL, 0);
        check("midrst_penable", PENABLE, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        PRESETn = 1'b1;
        step();
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_rsp_valid2", rsp_valid, 0);
        run_txn(32'h44, 1'b0, 32'h0, TO - 1, 32'h9ABCDEF0, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            run_txn($urandom, 1'($urandom), $urandom, int'($urandom_range(0, 11)), $urandom,
                    1'($urandom), int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
